pkt_header_parser: RTL

- Upstream stage of the per-node forwarding decision.
- On a start request, it reads a 6-byte packet header from the byte-wide packet memory starting at a given base address.
- It assembles the 16-bit destination ID, source ID and payload length, and validates the length.
- It then hands destinationID to the forwarding-decision stage with a one-cycle fwd_start pulse, plus a held done/error status.

---
 rtl/pkt_header_parser.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pkt_header_parser.sv
// Packet header parser: fetches a 6-byte big-endian header from byte-wide memory,
// assembles destination/source/length, validates the length and kicks the forwarder.
module pkt_header_parser #(
  parameter int MEM_DEPTH  = 1024,
  parameter int MEM_WIDTH  = 8,
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int HDR_BYTES  = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] pkt_base_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [MEM_WIDTH-1:0]  mem_rdata,
  output logic [WORD_WIDTH-1:0] destinationID,
  output logic [WORD_WIDTH-1:0] sourceID,
  output logic [WORD_WIDTH-1:0] payloadLength,
  output logic                  busy,
  output logic                  fwd_start,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_CHECK, S_DONE} state_t;

  localparam logic [2:0]            LAST_IDX = 3'(HDR_BYTES - 1);
  localparam logic [WORD_WIDTH-1:0] MAX_LEN  = WORD_WIDTH'(MEM_DEPTH - HDR_BYTES);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [2:0]              r_idx;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [WORD_WIDTH-1:0]   r_dest;
  logic [WORD_WIDTH-1:0]   r_src;
  logic [WORD_WIDTH-1:0]   r_len;
  logic                    r_error;
  logic                    r_first;
  logic                    w_accept;
  logic                    w_capture;
  logic [2:0]              w_cap_idx;
  logic                    w_error_next;

  assign w_accept     = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_error_next = (r_len == '0) || (r_len > MAX_LEN);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    mem_rd_en    = 1'b0;
    mem_addr     = '0;
    busy         = 1'b0;
    done         = 1'b0;
    fwd_start    = 1'b0;
    w_capture    = 1'b0;
    w_cap_idx    = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_FETCH;
      end
      S_FETCH: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        mem_addr  = r_base + ADDR_WIDTH'(r_idx);
        // read data lags the address by one cycle, so capture the previous byte
        w_capture = (r_idx != 3'd0);
        w_cap_idx = r_idx - 3'd1;
        if (r_idx == LAST_IDX) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy         = 1'b1;
        w_capture    = 1'b1;
        w_cap_idx    = LAST_IDX;
        w_state_next = S_CHECK;
      end
      S_CHECK: begin
        busy         = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        fwd_start = r_first && !r_error;
        if (start) w_state_next = S_FETCH;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idx   <= '0;
      r_base  <= '0;
      r_dest  <= '0;
      r_src   <= '0;
      r_len   <= '0;
      r_error <= 1'b0;
      r_first <= 1'b0;
    end else if (w_accept) begin
      r_base  <= pkt_base_addr;
      r_idx   <= '0;
      r_dest  <= '0;
      r_src   <= '0;
      r_len   <= '0;
      r_error <= 1'b0;
      r_first <= 1'b0;
    end else begin
      if (r_state == S_FETCH) r_idx <= r_idx + 3'd1;
      if (w_capture) begin
        // big-endian: even byte is the high half of each field
        case (w_cap_idx)
          3'd0:    r_dest[WORD_WIDTH-1 -: MEM_WIDTH] <= mem_rdata;
          3'd1:    r_dest[MEM_WIDTH-1:0]             <= mem_rdata;
          3'd2:    r_src[WORD_WIDTH-1 -: MEM_WIDTH]  <= mem_rdata;
          3'd3:    r_src[MEM_WIDTH-1:0]              <= mem_rdata;
          3'd4:    r_len[WORD_WIDTH-1 -: MEM_WIDTH]  <= mem_rdata;
          3'd5:    r_len[MEM_WIDTH-1:0]              <= mem_rdata;
          default: ;
        endcase
      end
      if (r_state == S_CHECK) begin
        r_error <= w_error_next;
        r_first <= 1'b1;
      end else if (r_state == S_DONE) begin
        r_first <= 1'b0;
      end
    end
  end

  assign destinationID = r_dest;
  assign sourceID      = r_src;
  assign payloadLength = r_len;
  assign error         = r_error;

endmodule
